chacha_block_core: RTL and testbench
====================================

Name: chacha_block_core

Overview:
- Iterative ChaCha block function (RFC 7539 layout: 4 constants, 8 key words, 32-bit counter, 3 nonce words) producing one 512-bit keystream block per request.
- Parametrised in round count (ChaCha8/12/20) and unroll factor: 4 quarterround instances per cycle (one column or diagonal round) or 8 chained instances (one double round).
- Sits between the key/nonce source and the keystream XOR/memory-encryption datapath; valid/ready on both sides.

Parameters:
- ROUNDS, 20, total rounds; legal 8, 12, 20 (even); other values are an elaboration error.
- QR_PER_CYCLE, 4, quarterrounds per cycle; 4 = one round per cycle, 8 = one double round per cycle; other values are an elaboration error.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  core can accept a request.
- key  input  256  key; word k = key[32k+31:32k], state word 4+k.
- counter  input  32  block counter, state word 12.
- nonce  input  96  nonce; word n = nonce[32n+31:32n], state word 13+n.
- out_valid  output  1  keystream block valid.
- out_ready  input  1  consumer accepts block.
- keystream  output  512  final state; word i = keystream[32i+31:32i].

Behaviour:
- Initial state: w0..w3 = 61707865, 3320646e, 79622d32, 6b206574 (hex); w4..w11 = key; w12 = counter; w13..w15 = nonce.
- Quarterround QR(a,b,c,d), all adds mod 2^32: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7.
- Column round: QR(0,4,8,12) QR(1,5,9,13) QR(2,6,10,14) QR(3,7,11,15).
- Diagonal round: QR(0,5,10,15) QR(1,6,11,12) QR(2,7,8,13) QR(3,4,9,14).
- Rounds alternate column, diagonal, starting with column.
- FSM states IDLE, ROUND, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, latch the initial state into both the working and saved-input registers, clear the step counter, go to ROUND.
  - ROUND: in_ready=0. Each cycle apply one step: with QR_PER_CYCLE=4 a single round, whose type is selected by the step counter LSB; with QR_PER_CYCLE=8 a column then a diagonal round, chained combinationally. Step counter increments.
  - Final step: NSTEPS = ROUNDS when QR_PER_CYCLE=4, ROUNDS/2 when 8. On the edge completing step NSTEPS, register keystream = working_next + saved input (word-wise, mod 2^32), set out_valid=1, go to DONE.
  - DONE: out_valid=1 and keystream held stable until out_ready. On out_valid&out_ready, out_valid=0 and return to IDLE. No new request is accepted in the handoff cycle.
- Latency: out_valid rises exactly NSTEPS clock edges after the accepting edge. That is 20 for defaults, 10 for ROUNDS=20/QR=8, and 4 for ROUNDS=8/QR=8. Throughput is one block per NSTEPS+2 cycles with out_ready held at 1.
- Input signals are sampled only on the accepting edge; changes at any other time are ignored.
- out_ready while out_valid=0 has no effect. in_valid held in ROUND or DONE is not accepted and not queued.
- Counter wrap: the counter is used as given. FFFFFFFF is legal, no carry into the nonce.
- Reset (asynchronous, any state including mid-ROUND or DONE): state=IDLE, out_valid=0, keystream=0, step counter=0, working and saved registers=0. in_ready=1 immediately after reset deasserts. An in-flight block is discarded, with no output.

Test Plan:
- RFC 7539 2.3.2 vector, defaults. Stimulus: key bytes 00..1f (w4=03020100), nonce words 09000000 4a000000 00000000, counter 00000001. Required: out_valid exactly 20 cycles after accept; keystream w0..w3 = e4e7f110 15593bd1 1fdd0f50 c47120a3 and w15 = 4e3c50a2.
- Same vector with QR_PER_CYCLE=8. Required: identical keystream, latency 10 cycles.
- ROUNDS=8 and ROUNDS=12, all-zero key/nonce/counter. Required: match the software reference model; latency 8 and 12 respectively.
- Backpressure: hold out_ready=0 for 15 cycles after out_valid, and change the inputs while in_valid=1. Required: keystream stable, in_ready=0 throughout, one block only. Release out_ready: in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 at step 7. Required: out_valid, keystream and in_ready take their reset values asynchronously. A new request after release gives a correct block with no residue.
- Counter FFFFFFFF. Required: w12 of the output equals the model with the counter at FFFFFFFF. Then a back-to-back request with counter 00000000 produces an independent, correct block.

Source files
------------

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function (RFC 7539 state layout) with valid/ready on both sides.
// Applies one round (4 QRs) or one double round (8 QRs) per clock.
`timescale 1ns/1ps
module chacha_block_core #(
  parameter int ROUNDS       = 20,
  parameter int QR_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [31:0]  counter,
  input  logic [95:0]  nonce,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] keystream
);

  localparam int NSTEPS = (QR_PER_CYCLE == 8) ? (ROUNDS / 2) : ROUNDS;
  localparam int STEP_W = $clog2(NSTEPS + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

  if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
    $error("chacha_block_core: ROUNDS must be 8, 12 or 20");
  end
  if (!(QR_PER_CYCLE == 4 || QR_PER_CYCLE == 8)) begin : g_bad_qr
    $error("chacha_block_core: QR_PER_CYCLE must be 4 or 8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [511:0]        work_q, work_d;
  logic [511:0]        saved_q, saved_d;
  logic [511:0]        keystream_q, keystream_d;
  logic                outValid_q, outValid_d;
  logic [511:0]        initState;
  logic [511:0]        workNext;

  function automatic logic [127:0] quarterRound(input logic [31:0] aIn, input logic [31:0] bIn,
                                                input logic [31:0] cIn, input logic [31:0] dIn);
    logic [31:0] a, b, c, d;
    a = aIn;
    b = bIn;
    c = cIn;
    d = dIn;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {d, c, b, a};
  endfunction

  function automatic logic [511:0] applyQr(input logic [511:0] s, input int ia, input int ib,
                                           input int ic, input int id);
    logic [511:0] r;
    logic [127:0] q;
    r = s;
    q = quarterRound(s[32*ia +: 32], s[32*ib +: 32], s[32*ic +: 32], s[32*id +: 32]);
    r[32*ia +: 32] = q[31:0];
    r[32*ib +: 32] = q[63:32];
    r[32*ic +: 32] = q[95:64];
    r[32*id +: 32] = q[127:96];
    return r;
  endfunction

  // The four QRs of a round touch disjoint words, so sequencing them is the same as running them in parallel.
  function automatic logic [511:0] columnRound(input logic [511:0] s);
    logic [511:0] r;
    r = applyQr(s, 0, 4, 8, 12);
    r = applyQr(r, 1, 5, 9, 13);
    r = applyQr(r, 2, 6, 10, 14);
    r = applyQr(r, 3, 7, 11, 15);
    return r;
  endfunction

  function automatic logic [511:0] diagonalRound(input logic [511:0] s);
    logic [511:0] r;
    r = applyQr(s, 0, 5, 10, 15);
    r = applyQr(r, 1, 6, 11, 12);
    r = applyQr(r, 2, 7, 8, 13);
    r = applyQr(r, 3, 4, 9, 14);
    return r;
  endfunction

  function automatic logic [511:0] addWords(input logic [511:0] x, input logic [511:0] y);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) begin
      r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    end
    return r;
  endfunction

  always_comb begin
    initState = {nonce, counter, key,
                 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  end

  if (QR_PER_CYCLE == 8) begin : g_double
    always_comb begin
      workNext = diagonalRound(columnRound(work_q));
    end
  end else begin : g_single
    // Even steps are column rounds, odd steps diagonal rounds.
    always_comb begin
      workNext = step_q[0] ? diagonalRound(work_q) : columnRound(work_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    work_d      = work_q;
    saved_d     = saved_q;
    keystream_d = keystream_q;
    outValid_d  = outValid_q;
    in_ready    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = initState;
          saved_d = initState;
          step_d  = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        work_d = workNext;
        step_d = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) begin
          keystream_d = addWords(workNext, saved_q);
          outValid_d  = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      work_q      <= '0;
      saved_q     <= '0;
      keystream_q <= '0;
      outValid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      work_q      <= work_d;
      saved_q     <= saved_d;
      keystream_q <= keystream_d;
      outValid_q  <= outValid_d;
    end
  end

  assign out_valid = outValid_q;
  assign keystream = keystream_q;

endmodule

// File: tb/tb_chacha_block_core.sv
// Scoreboard bench for chacha_block_core: five instances covering ROUNDS/QR_PER_CYCLE variants.
`timescale 1ns/1ps
module tb_chacha_block_core;

  localparam int NDUT = 5;

  function automatic int roundsOf(input int i);
    case (i)
      0: return 20;
      1: return 20;
      2: return 8;
      3: return 12;
      default: return 8;
    endcase
  endfunction

  function automatic int qrOf(input int i);
    case (i)
      1: return 8;
      4: return 8;
      default: return 4;
    endcase
  endfunction

  function automatic int nstepsOf(input int i);
    return (qrOf(i) == 8) ? roundsOf(i) / 2 : roundsOf(i);
  endfunction

  typedef struct packed {
    logic [511:0] ks;
    int           acceptCyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstN;
  logic         inValid   [NDUT];
  logic         inReady   [NDUT];
  logic [255:0] keyIn     [NDUT];
  logic [31:0]  ctrIn     [NDUT];
  logic [95:0]  nonceIn   [NDUT];
  logic         outValid  [NDUT];
  logic         outReady  [NDUT];
  logic [511:0] keystream [NDUT];

  exp_t         expQ [NDUT][$];
  logic         seen [NDUT];
  logic [511:0] held [NDUT];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    chacha_block_core #(
      .ROUNDS      (roundsOf(g)),
      .QR_PER_CYCLE(qrOf(g))
    ) dut (
      .clk      (clk),
      .rst_n    (rstN),
      .in_valid (inValid[g]),
      .in_ready (inReady[g]),
      .key      (keyIn[g]),
      .counter  (ctrIn[g]),
      .nonce    (nonceIn[g]),
      .out_valid(outValid[g]),
      .out_ready(outReady[g]),
      .keystream(keystream[g])
    );
  end

  // Independent software model of the block function.
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic void qrm(inout logic [31:0] a, inout logic [31:0] b,
                              inout logic [31:0] c, inout logic [31:0] d);
    a += b; d ^= a; d = rotl(d, 16);
    c += d; b ^= c; b = rotl(b, 12);
    a += b; d ^= a; d = rotl(d, 8);
    c += d; b ^= c; b = rotl(b, 7);
  endfunction

  function automatic logic [511:0] chachaModel(input logic [255:0] k, input logic [31:0] c,
                                               input logic [95:0] n, input int rounds);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int j = 0; j < 8; j++) s[4+j] = k[32*j +: 32];
    s[12] = c;
    for (int j = 0; j < 3; j++) s[13+j] = n[32*j +: 32];
    x = s;
    for (int rd = 0; rd < rounds; rd += 2) begin
      qrm(x[0], x[4], x[8],  x[12]);
      qrm(x[1], x[5], x[9],  x[13]);
      qrm(x[2], x[6], x[10], x[14]);
      qrm(x[3], x[7], x[11], x[15]);
      qrm(x[0], x[5], x[10], x[15]);
      qrm(x[1], x[6], x[11], x[12]);
      qrm(x[2], x[7], x[8],  x[13]);
      qrm(x[3], x[4], x[9],  x[14]);
    end
    for (int j = 0; j < 16; j++) r[32*j +: 32] = x[j] + s[j];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] got, input logic [511:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        if (!rstN) begin
          seen[i] = 1'b0;
          continue;
        end
        if (outValid[i]) begin
          if (!seen[i]) begin
            seen[i] = 1'b1;
            held[i] = keystream[i];
            checkOutput($sformatf("block_expected_dut%0d", i), 512'(expQ[i].size() != 0), 512'(1));
            if (expQ[i].size() != 0)
              checkOutput($sformatf("latency_dut%0d", i), 512'(cyc - expQ[i][0].acceptCyc),
                          512'(nstepsOf(i)));
          end else begin
            checkOutput($sformatf("ks_stable_dut%0d", i), keystream[i], held[i]);
          end
          checkOutput($sformatf("in_ready_done_dut%0d", i), 512'(inReady[i]), 512'(0));
          if (outReady[i]) begin
            if (expQ[i].size() != 0) begin
              e = expQ[i].pop_front();
              checkOutput($sformatf("keystream_dut%0d", i), keystream[i], e.ks);
            end
            seen[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input int i, input logic [255:0] k, input logic [31:0] c,
                               input logic [95:0] n, input logic [511:0] want);
    exp_t e;
    int   waitCyc;
    waitCyc = 0;
    @(posedge clk); #1;
    keyIn[i]   = k;
    ctrIn[i]   = c;
    nonceIn[i] = n;
    inValid[i] = 1'b1;
    while (!inReady[i] && waitCyc < 100) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    checkOutput($sformatf("accept_dut%0d", i), 512'(inReady[i]), 512'(1));
    e.ks        = want;
    e.acceptCyc = cyc + 1;
    expQ[i].push_back(e);
    @(posedge clk); #1;
    inValid[i] = 1'b0;
  endtask

  task automatic waitDrain(input int i);
    int n;
    n = 0;
    while (expQ[i].size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput($sformatf("drain_dut%0d", i), 512'(expQ[i].size()), 512'(0));
  endtask

  logic [255:0] rfcKey;
  logic [95:0]  rfcNonce;
  logic [511:0] rfcWant;

  initial begin
    #500us;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      inValid[i] = 1'b0; outReady[i] = 1'b1; keyIn[i] = '0; ctrIn[i] = '0; nonceIn[i] = '0;
      seen[i] = 1'b0; held[i] = '0;
    end
    for (int j = 0; j < 32; j++) rfcKey[8*j +: 8] = 8'(j);
    rfcNonce = 96'h00000000_4a000000_09000000;
    // Hand-computed RFC 7539 block-function output words; the rest comes from the model.
    rfcWant = chachaModel(rfcKey, 32'h1, rfcNonce, 20);
    rfcWant[31:0]    = 32'he4e7f110;
    rfcWant[63:32]   = 32'h15593bd1;
    rfcWant[95:64]   = 32'h1fdd0f50;
    rfcWant[127:96]  = 32'hc47120a3;
    rfcWant[511:480] = 32'h4e3c50a2;

    rstN = 1'b1;
    #2 rstN = 1'b0;
    fork monitor(); join_none
    #1;
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("rst_out_valid_dut%0d", i), 512'(outValid[i]), 512'(0));
      checkOutput($sformatf("rst_in_ready_dut%0d", i), 512'(inReady[i]), 512'(1));
      checkOutput($sformatf("rst_keystream_dut%0d", i), keystream[i], 512'(0));
    end
    #20 rstN = 1'b1;

    applyStimulus(0, rfcKey, 32'h1, rfcNonce, rfcWant);
    waitDrain(0);
    applyStimulus(1, rfcKey, 32'h1, rfcNonce, rfcWant);
    waitDrain(1);
    for (int i = 2; i < NDUT; i++) begin
      applyStimulus(i, '0, '0, '0, chachaModel('0, '0, '0, roundsOf(i)));
      waitDrain(i);
    end
    applyStimulus(4, rfcKey, 32'h1, rfcNonce, chachaModel(rfcKey, 32'h1, rfcNonce, 8));
    waitDrain(4);

    // Backpressure: hold the block for 15 cycles while in_valid stays high with changing inputs.
    outReady[0] = 1'b0;
    applyStimulus(0, ~rfcKey, 32'h5, 96'h123456789abcdef0_11223344,
                  chachaModel(~rfcKey, 32'h5, 96'h123456789abcdef0_11223344, 20));
    inValid[0] = 1'b1;
    for (int n = 0; n < 50 && !outValid[0]; n++) begin
      keyIn[0] = {keyIn[0][254:0], keyIn[0][255]};
      ctrIn[0] = ctrIn[0] + 32'd3;
      @(posedge clk); #1;
    end
    checkOutput("bp_valid_seen", 512'(outValid[0]), 512'(1));
    for (int n = 0; n < 15; n++) begin
      keyIn[0]   = ~keyIn[0];
      nonceIn[0] = nonceIn[0] + 96'd7;
      checkOutput("bp_in_ready_low", 512'(inReady[0]), 512'(0));
      @(posedge clk); #1;
    end
    inValid[0]  = 1'b0;
    outReady[0] = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_in_ready_after", 512'(inReady[0]), 512'(1));
    checkOutput("bp_out_valid_after", 512'(outValid[0]), 512'(0));
    waitDrain(0);
    repeat (5) @(posedge clk);

    // Asynchronous reset during step 7 discards the in-flight block.
    applyStimulus(0, rfcKey, 32'h1, rfcNonce, rfcWant);
    repeat (7) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 512'(outValid[0]), 512'(0));
    checkOutput("midrst_keystream", keystream[0], 512'(0));
    checkOutput("midrst_in_ready", 512'(inReady[0]), 512'(1));
    expQ[0].delete();
    @(posedge clk); #3 rstN = 1'b1;
    applyStimulus(0, rfcKey, 32'h1, rfcNonce, rfcWant);
    waitDrain(0);

    // Counter wrap value, then a back-to-back request with counter 0.
    applyStimulus(0, rfcKey, 32'hffffffff, rfcNonce, chachaModel(rfcKey, 32'hffffffff, rfcNonce, 20));
    applyStimulus(0, rfcKey, 32'h0, rfcNonce, chachaModel(rfcKey, 32'h0, rfcNonce, 20));
    waitDrain(0);
    applyStimulus(1, rfcKey, 32'hffffffff, rfcNonce, chachaModel(rfcKey, 32'hffffffff, rfcNonce, 20));
    applyStimulus(1, '0, 32'h0, '0, chachaModel('0, 32'h0, '0, 20));
    waitDrain(1);

    repeat (30) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
